// File: rtl/ysyx_23060187_ifu_fetch.sv
// Multi-cycle instruction fetch unit: one outstanding 32-bit read per instruction,
// result handed to the IDU over valid/ready, next PC supplied by write-back.
module ysyx_23060187_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_mem_req,
    output logic [31:0] ifu_mem_addr,
    input  logic        mem_ifu_gnt,
    input  logic        mem_ifu_rvalid,
    input  logic [31:0] mem_ifu_rdata,
    input  logic        mem_ifu_err,
    output logic        IFU_IDU_valid,
    input  logic        IDU_IFU_ready,
    output logic [31:0] IFU_IDU_inst,
    output logic [31:0] IFU_IDU_pc,
    output logic        IFU_IDU_fault,
    input  logic        WBU_IFU_valid,
    input  logic [31:0] WBU_IFU_pc
);

    typedef enum logic [1:0] {
        REQ,
        WAIT_RSP,
        SEND,
        WAIT_PC
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        fault_q, fault_d;
    logic        pc_misaligned;

    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            inst_q   <= NOP_INST;
            out_pc_q <= RESET_PC;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            out_pc_q <= out_pc_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        out_pc_d = out_pc_q;
        fault_d  = fault_q;
        case (state_q)
            REQ: begin
                // A misaligned PC never reaches the bus; it is reported as a fault instead.
                if (pc_misaligned) begin
                    inst_d   = NOP_INST;
                    out_pc_d = pc_q;
                    fault_d  = 1'b1;
                    state_d  = SEND;
                end else if (mem_ifu_gnt) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_ifu_rvalid) begin
                    out_pc_d = pc_q;
                    fault_d  = mem_ifu_err;
                    inst_d   = mem_ifu_err ? NOP_INST : mem_ifu_rdata;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (IDU_IFU_ready) begin
                    state_d = WAIT_PC;
                end
            end
            WAIT_PC: begin
                if (WBU_IFU_valid) begin
                    pc_d    = WBU_IFU_pc;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    assign ifu_mem_req   = (state_q == REQ) && !pc_misaligned;
    assign ifu_mem_addr  = pc_q;
    assign IFU_IDU_valid = (state_q == SEND);
    assign IFU_IDU_inst  = inst_q;
    assign IFU_IDU_pc    = out_pc_q;
    assign IFU_IDU_fault = fault_q;

endmodule

// File: tb/tb_ysyx_23060187_ifu_fetch.sv
// Self-checking bench for the fetch unit: directed scenarios followed by randomized
// fetch transactions checked against a transaction-level expectation of the interfaces.
module tb_ysyx_23060187_ifu_fetch;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_mem_req;
    logic [31:0] ifu_mem_addr;
    logic        mem_ifu_gnt;
    logic        mem_ifu_rvalid;
    logic [31:0] mem_ifu_rdata;
    logic        mem_ifu_err;
    logic        IFU_IDU_valid;
    logic        IDU_IFU_ready;
    logic [31:0] IFU_IDU_inst;
    logic [31:0] IFU_IDU_pc;
    logic        IFU_IDU_fault;
    logic        WBU_IFU_valid;
    logic [31:0] WBU_IFU_pc;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    ysyx_23060187_ifu_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_mem_req   (ifu_mem_req),
        .ifu_mem_addr  (ifu_mem_addr),
        .mem_ifu_gnt   (mem_ifu_gnt),
        .mem_ifu_rvalid(mem_ifu_rvalid),
        .mem_ifu_rdata (mem_ifu_rdata),
        .mem_ifu_err   (mem_ifu_err),
        .IFU_IDU_valid (IFU_IDU_valid),
        .IDU_IFU_ready (IDU_IFU_ready),
        .IFU_IDU_inst  (IFU_IDU_inst),
        .IFU_IDU_pc    (IFU_IDU_pc),
        .IFU_IDU_fault (IFU_IDU_fault),
        .WBU_IFU_valid (WBU_IFU_valid),
        .WBU_IFU_pc    (WBU_IFU_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_ifu_gnt    = 1'b0;
        mem_ifu_rvalid = 1'b0;
        mem_ifu_rdata  = 32'h0;
        mem_ifu_err    = 1'b0;
        IDU_IFU_ready  = 1'b0;
        WBU_IFU_valid  = 1'b0;
        WBU_IFU_pc     = 32'h0;
    endtask

    // Nothing offered to the IDU; request line as expected; address tracks the model PC.
    task automatic chk_quiet(input string tag, input logic exp_req);
        chk({tag, ".req"}, {31'b0, ifu_mem_req}, {31'b0, exp_req});
        chk({tag, ".addr"}, ifu_mem_addr, m_pc);
        chk({tag, ".valid"}, {31'b0, IFU_IDU_valid}, 32'h0);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                           input logic fault);
        chk({tag, ".valid"}, {31'b0, IFU_IDU_valid}, 32'h1);
        chk({tag, ".req"}, {31'b0, ifu_mem_req}, 32'h0);
        chk({tag, ".inst"}, IFU_IDU_inst, inst);
        chk({tag, ".pc"}, IFU_IDU_pc, pc);
        chk({tag, ".fault"}, {31'b0, IFU_IDU_fault}, {31'b0, fault});
    endtask

    // One full instruction: request, response, IDU handshake, next PC from WBU.
    task automatic do_fetch(input string tag, input int gnt_dly, input int rsp_dly,
                            input int ready_dly, input int wbu_dly, input logic [31:0] rdata,
                            input logic err, input logic [31:0] next_pc, input logic stray);
        logic [31:0] exp_inst;
        logic        exp_fault;
        if (m_pc[1:0] != 2'b00) begin
            chk_quiet({tag, ".misal"}, 1'b0);
            step();
            exp_inst  = NOP;
            exp_fault = 1'b1;
        end else begin
            for (int i = 0; i < gnt_dly; i++) begin
                chk_quiet({tag, ".stall"}, 1'b1);
                step();
            end
            chk_quiet({tag, ".gnt"}, 1'b1);
            mem_ifu_gnt = 1'b1;
            step();
            mem_ifu_gnt = 1'b0;
            for (int i = 0; i < rsp_dly; i++) begin
                chk_quiet({tag, ".rspwait"}, 1'b0);
                WBU_IFU_valid = stray;
                WBU_IFU_pc    = ~m_pc;
                step();
                WBU_IFU_valid = 1'b0;
            end
            chk_quiet({tag, ".rsp"}, 1'b0);
            mem_ifu_rvalid = 1'b1;
            mem_ifu_rdata  = rdata;
            mem_ifu_err    = err;
            step();
            mem_ifu_rvalid = 1'b0;
            mem_ifu_err    = 1'b0;
            exp_inst  = err ? NOP : rdata;
            exp_fault = err;
        end
        for (int i = 0; i < ready_dly; i++) begin
            chk_out({tag, ".hold"}, exp_inst, m_pc, exp_fault);
            mem_ifu_rvalid = stray;
            mem_ifu_rdata  = ~rdata;
            WBU_IFU_valid  = stray;
            WBU_IFU_pc     = ~m_pc;
            step();
            mem_ifu_rvalid = 1'b0;
            WBU_IFU_valid  = 1'b0;
        end
        chk_out({tag, ".hs"}, exp_inst, m_pc, exp_fault);
        IDU_IFU_ready = 1'b1;
        step();
        IDU_IFU_ready = 1'b0;
        for (int i = 0; i < wbu_dly; i++) begin
            chk_quiet({tag, ".pcwait"}, 1'b0);
            mem_ifu_rvalid = stray;
            mem_ifu_gnt    = stray;
            IDU_IFU_ready  = stray;
            step();
            mem_ifu_rvalid = 1'b0;
            mem_ifu_gnt    = 1'b0;
            IDU_IFU_ready  = 1'b0;
        end
        chk_quiet({tag, ".wbu"}, 1'b0);
        WBU_IFU_valid = 1'b1;
        WBU_IFU_pc    = next_pc;
        step();
        WBU_IFU_valid = 1'b0;
        m_pc = next_pc;
    endtask

    initial begin
        logic [31:0] npc;
        drive_idle();
        rst  = 1'b1;
        m_pc = RPC;
        step();
        step();
        chk("rst.valid", {31'b0, IFU_IDU_valid}, 32'h0);
        chk("rst.inst", IFU_IDU_inst, NOP);
        chk("rst.pc", IFU_IDU_pc, RPC);
        chk("rst.fault", {31'b0, IFU_IDU_fault}, 32'h0);
        rst = 1'b0;

        // Fastest fetch, then IDU stalls 4 cycles, WBU redirects to 0x80000010.
        do_fetch("t1", 0, 0, 4, 2, 32'h0050_0093, 1'b0, 32'h8000_0010, 1'b0);
        // Grant stalled 3 cycles, bus error on the response, next PC misaligned.
        do_fetch("t3", 3, 1, 1, 0, 32'hdead_beef, 1'b1, 32'h8000_0006, 1'b1);
        // Misaligned PC faults without touching the bus.
        do_fetch("t5", 0, 0, 2, 1, 32'h0, 1'b0, 32'h8000_0020, 1'b1);

        // Reset while waiting for the response; a late stray response must be ignored.
        chk_quiet("t6.req", 1'b1);
        mem_ifu_gnt = 1'b1;
        step();
        mem_ifu_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst  = 1'b0;
        m_pc = RPC;
        mem_ifu_rvalid = 1'b1;
        mem_ifu_rdata  = 32'h1234_5678;
        step();
        mem_ifu_rvalid = 1'b0;
        chk_quiet("t6.after", 1'b1);
        chk("t6.inst", IFU_IDU_inst, NOP);
        chk("t6.pc", IFU_IDU_pc, RPC);

        // Reset while valid is high drops valid and restores the reset values.
        mem_ifu_gnt = 1'b1;
        step();
        mem_ifu_gnt    = 1'b0;
        mem_ifu_rvalid = 1'b1;
        mem_ifu_rdata  = 32'h0aaa_5555;
        step();
        mem_ifu_rvalid = 1'b0;
        chk_out("t7.valid", 32'h0aaa_5555, RPC, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_quiet("t7.rst", 1'b1);
        chk("t7.inst", IFU_IDU_inst, NOP);

        for (int n = 0; n < 40; n++) begin
            npc = $urandom;
            if ($urandom_range(0, 5) == 0) npc[1:0] = 2'($urandom_range(1, 3));
            else npc[1:0] = 2'b00;
            do_fetch("rnd", $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 3) == 0), npc,
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
